// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard tracker.
// Stage entries carry a fixed-width destination field so every stage register shares one payload type.
package hazard_pkg;

    localparam int unsigned MAX_RB = 8;
    localparam int unsigned FWD_RF = 0;

    typedef struct packed {
        logic              valid;
        logic              we;
        logic [MAX_RB-1:0] dst;
        logic              load;
    } stage_entry_t;

    function automatic int unsigned fwd_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // An entry produces addr unless it is a bubble, does not write, or targets the PC.
    function automatic logic entry_match(input stage_entry_t e,
                                         input logic [MAX_RB-1:0] addr,
                                         input logic [MAX_RB-1:0] pc);
        return e.valid && e.we && (e.dst == addr) && (addr != pc);
    endfunction

endpackage

// File: rtl/hz_stage_reg.sv
// One tracked pipeline stage: holds the in-flight destination entry, clearable by a bubble.
module hz_stage_reg
    import hazard_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         bubble,
    input  stage_entry_t d,
    output stage_entry_t q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (bubble) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/hazard_tracker.sv
// Generic hazard unit: per-operand forwarding selects for E, load-use stalls,
// branch flushes and a saturating stall-cycle counter.
module hazard_tracker
    import hazard_pkg::*;
#(
    parameter  int unsigned RB         = 4,
    parameter  int unsigned NSRC       = 2,
    parameter  int unsigned DEPTH      = 3,
    parameter  int unsigned LOAD_STAGE = 3,
    parameter  int unsigned PC_REG     = 15,
    parameter  int unsigned CNT_W      = 16,
    localparam int unsigned FW         = fwd_width(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 id_valid,
    input  logic [NSRC*RB-1:0]   id_src,
    input  logic [NSRC-1:0]      id_src_used,
    input  logic [RB-1:0]        id_dst,
    input  logic                 id_we,
    input  logic                 id_load,
    input  logic                 br_taken_e,
    output logic [NSRC*FW-1:0]   fwd_sel,
    output logic                 stall_f,
    output logic                 stall_d,
    output logic                 flush_d,
    output logic                 flush_e,
    output logic [CNT_W-1:0]     stall_cycles
);

    localparam logic [MAX_RB-1:0] PC_ADDR = MAX_RB'(PC_REG);
    // Last stage whose load result is not yet forwardable to a Decode consumer.
    localparam int HZ_LAST = ((int'(LOAD_STAGE) - 2) < int'(DEPTH)) ? (int'(LOAD_STAGE) - 2) : int'(DEPTH);

    stage_entry_t      ent [1:DEPTH];
    stage_entry_t      d_entry;
    logic [RB-1:0]     e_src [NSRC];
    logic [NSRC-1:0]   e_used;
    logic              hz;
    logic              bubble_e;
    logic              stall_int;
    logic [CNT_W-1:0]  cnt;
    logic [FW-1:0]     sel_chain [NSRC][2:DEPTH+1];

    always_comb begin
        d_entry       = '0;
        d_entry.valid = id_valid;
        d_entry.we    = id_we;
        d_entry.dst   = MAX_RB'(id_dst);
        d_entry.load  = id_load;
    end

    // Stage 1 captures Decode or a bubble; later stages shift unconditionally.
    genvar gk;
    generate
        for (gk = 1; gk <= int'(DEPTH); gk++) begin : g_stage
            if (gk == 1) begin : g_first
                hz_stage_reg u_reg (
                    .clk    (clk),
                    .reset  (reset),
                    .bubble (bubble_e),
                    .d      (d_entry),
                    .q      (ent[1])
                );
            end else begin : g_rest
                hz_stage_reg u_reg (
                    .clk    (clk),
                    .reset  (reset),
                    .bubble (1'b0),
                    .d      (ent[gk-1]),
                    .q      (ent[gk])
                );
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_used <= '0;
            for (int i = 0; i < int'(NSRC); i++) begin
                e_src[i] <= '0;
            end
        end else if (bubble_e) begin
            e_used <= '0;
            for (int i = 0; i < int'(NSRC); i++) begin
                e_src[i] <= '0;
            end
        end else begin
            e_used <= id_src_used;
            for (int i = 0; i < int'(NSRC); i++) begin
                e_src[i] <= id_src[i*RB +: RB];
            end
        end
    end

    // Load-use: a Decode operand depends on a load too young to forward.
    always_comb begin
        hz = 1'b0;
        for (int i = 0; i < int'(NSRC); i++) begin
            for (int k = 1; k <= HZ_LAST; k++) begin
                if (id_src_used[i] && ent[k].load &&
                    entry_match(ent[k], MAX_RB'(id_src[i*RB +: RB]), PC_ADDR)) begin
                    hz = 1'b1;
                end
            end
        end
        hz = hz & id_valid;
    end

    assign bubble_e  = br_taken_e | hz;
    assign stall_int = ~br_taken_e & hz;

    assign stall_f      = ~reset & stall_int;
    assign stall_d      = ~reset & stall_int;
    assign flush_d      = ~reset & br_taken_e;
    assign flush_e      = ~reset & bubble_e;
    assign stall_cycles = cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (stall_int && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Priority chain from the oldest stage toward stage 2, so the youngest producer wins.
    genvar gi, gs;
    generate
        for (gi = 0; gi < int'(NSRC); gi++) begin : g_op
            assign sel_chain[gi][DEPTH+1] = FW'(FWD_RF);
            for (gs = int'(DEPTH); gs >= 2; gs--) begin : g_scan
                assign sel_chain[gi][gs] =
                    (e_used[gi] && entry_match(ent[gs], MAX_RB'(e_src[gi]), PC_ADDR))
                    ? FW'(gs) : sel_chain[gi][gs+1];
            end
            assign fwd_sel[gi*FW +: FW] = reset ? FW'(FWD_RF) : sel_chain[gi][2];
        end
    endgenerate

endmodule

// File: tb/tb_hazard_tracker.sv
// Bench for hazard_tracker: default (3/3) and deeper (4/4) instances against a
// per-instruction reference pipeline, with directed scenarios then random traffic.
module tb_hazard_tracker;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [7:0]  id_src;
    logic [1:0]  id_src_used;
    logic [3:0]  id_dst;
    logic        id_we;
    logic        id_load;
    logic        br_taken_e;

    logic [3:0]  a_fwd;
    logic        a_stall_f, a_stall_d, a_flush_d, a_flush_e;
    logic [15:0] a_cnt;
    logic [5:0]  b_fwd;
    logic        b_stall_f, b_stall_d, b_flush_d, b_flush_e;
    logic [15:0] b_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_tracker u_a (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_src(id_src),
        .id_src_used(id_src_used), .id_dst(id_dst), .id_we(id_we), .id_load(id_load),
        .br_taken_e(br_taken_e), .fwd_sel(a_fwd), .stall_f(a_stall_f), .stall_d(a_stall_d),
        .flush_d(a_flush_d), .flush_e(a_flush_e), .stall_cycles(a_cnt)
    );

    hazard_tracker #(.DEPTH(4), .LOAD_STAGE(4)) u_b (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_src(id_src),
        .id_src_used(id_src_used), .id_dst(id_dst), .id_we(id_we), .id_load(id_load),
        .br_taken_e(br_taken_e), .fwd_sel(b_fwd), .stall_f(b_stall_f), .stall_d(b_stall_d),
        .flush_d(b_flush_d), .flush_e(b_flush_e), .stall_cycles(b_cnt)
    );

    // Reference: each stage holds the instruction record that occupies it.
    typedef struct {
        bit valid;
        bit we;
        bit load;
        int dst;
    } rec_t;

    rec_t pipe   [2][1:4];
    int   e_src  [2][2];
    bit   e_used [2][2];
    int   cnt    [2];

    function automatic int dep(int m);
        return (m == 0) ? 3 : 4;
    endfunction

    function automatic bit hit(int m, int k, int a);
        return pipe[m][k].valid && pipe[m][k].we && (pipe[m][k].dst == a) && (a != 15);
    endfunction

    function automatic int exp_fwd(int m, int i);
        if (!e_used[m][i]) return 0;
        for (int k = 2; k <= dep(m); k++) begin
            if (hit(m, k, e_src[m][i])) return k;
        end
        return 0;
    endfunction

    // Load too young to forward: it sits in a stage below LOAD_STAGE-1.
    function automatic bit exp_hz(int m);
        logic [7:0] s;
        s = id_src;
        if (!id_valid) return 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (id_src_used[i]) begin
                for (int k = 1; k <= dep(m) - 2; k++) begin
                    if (hit(m, k, int'(s[i*4 +: 4])) && pipe[m][k].load) return 1'b1;
                end
            end
        end
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input int exp);
        checks++;
        assert (got === 32'(exp)) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int k = 1; k <= 4; k++) pipe[m][k] = '{valid: 1'b0, we: 1'b0, load: 1'b0, dst: 0};
            for (int i = 0; i < 2; i++) begin
                e_src[m][i]  = 0;
                e_used[m][i] = 1'b0;
            end
            cnt[m] = 0;
        end
    endtask

    task automatic compare_all();
        for (int m = 0; m < 2; m++) begin
            bit    h;
            bit    br;
            string p;
            h  = exp_hz(m);
            br = br_taken_e;
            p  = (m == 0) ? "a." : "b.";
            chk({p, "fwd0"},    (m == 0) ? 32'(a_fwd[1:0]) : 32'(b_fwd[2:0]), exp_fwd(m, 0));
            chk({p, "fwd1"},    (m == 0) ? 32'(a_fwd[3:2]) : 32'(b_fwd[5:3]), exp_fwd(m, 1));
            chk({p, "stall_f"}, (m == 0) ? 32'(a_stall_f) : 32'(b_stall_f), int'(!br && h));
            chk({p, "stall_d"}, (m == 0) ? 32'(a_stall_d) : 32'(b_stall_d), int'(!br && h));
            chk({p, "flush_d"}, (m == 0) ? 32'(a_flush_d) : 32'(b_flush_d), int'(br));
            chk({p, "flush_e"}, (m == 0) ? 32'(a_flush_e) : 32'(b_flush_e), int'(br || h));
            chk({p, "count"},   (m == 0) ? 32'(a_cnt) : 32'(b_cnt), cnt[m]);
        end
    endtask

    task automatic model_step();
        logic [7:0] s;
        s = id_src;
        for (int m = 0; m < 2; m++) begin
            bit h;
            bit br;
            h  = exp_hz(m);
            br = br_taken_e;
            if (!br && h && cnt[m] < 65535) cnt[m]++;
            for (int k = dep(m); k >= 2; k--) pipe[m][k] = pipe[m][k-1];
            if (br || h) begin
                pipe[m][1] = '{valid: 1'b0, we: 1'b0, load: 1'b0, dst: 0};
                for (int i = 0; i < 2; i++) begin
                    e_src[m][i]  = 0;
                    e_used[m][i] = 1'b0;
                end
            end else begin
                pipe[m][1] = '{valid: id_valid, we: id_we, load: id_load, dst: int'(id_dst)};
                for (int i = 0; i < 2; i++) begin
                    e_src[m][i]  = int'(s[i*4 +: 4]);
                    e_used[m][i] = id_src_used[i];
                end
            end
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".a_fwd"},  32'(a_fwd), 0);
        chk({tag, ".a_ctl"},  32'({a_stall_f, a_stall_d, a_flush_d, a_flush_e}), 0);
        chk({tag, ".a_cnt"},  32'(a_cnt), 0);
        chk({tag, ".b_fwd"},  32'(b_fwd), 0);
        chk({tag, ".b_ctl"},  32'({b_stall_f, b_stall_d, b_flush_d, b_flush_e}), 0);
        chk({tag, ".b_cnt"},  32'(b_cnt), 0);
    endtask

    task automatic drive(input bit v, input logic [3:0] s0, input logic [3:0] s1,
                         input logic [1:0] used, input logic [3:0] dst,
                         input bit we, input bit ld, input bit br);
        id_valid    = v;
        id_src      = {s1, s0};
        id_src_used = used;
        id_dst      = dst;
        id_we       = we;
        id_load     = ld;
        br_taken_e  = br;
    endtask

    task automatic nop();
        drive(1'b0, 4'd0, 4'd0, 2'b00, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic eval_cycle();
        @(negedge clk);
        compare_all();
    endtask

    task automatic adv();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        eval_cycle();
        adv();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        check_zero("reset");
        @(posedge clk);
        #1;
        model_reset();
        reset = 1'b0;
    endtask

    function automatic logic [3:0] pick_reg();
        int r;
        r = int'($urandom_range(0, 4));
        return (r == 4) ? 4'd15 : 4'(r);
    endfunction

    initial begin
        reset = 1'b1;
        nop();
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // ADD r1,r2,r3 ; SUB r4,r1,r5 back-to-back
        drive(1, 4'd2, 4'd3, 2'b11, 4'd1, 1, 0, 0); step();
        drive(1, 4'd1, 4'd5, 2'b11, 4'd4, 1, 0, 0); step();
        nop(); eval_cycle();
        chk("addsub.fwd0", 32'(a_fwd[1:0]), 2);
        chk("addsub.fwd1", 32'(a_fwd[3:2]), 0);
        chk("addsub.stall", 32'(a_stall_d), 0);
        adv();
        for (int n = 0; n < 4; n++) step();

        // ADD r1 ; NOP ; SUB r4,r1,r5
        drive(1, 4'd2, 4'd3, 2'b11, 4'd1, 1, 0, 0); step();
        nop(); step();
        drive(1, 4'd1, 4'd5, 2'b11, 4'd4, 1, 0, 0); step();
        nop(); eval_cycle();
        chk("gap.fwd0", 32'(a_fwd[1:0]), 3);
        adv();

        // ADD r1 in W and ORR r1 in M: youngest wins
        drive(1, 4'd2, 4'd3, 2'b11, 4'd1, 1, 0, 0); step();
        drive(1, 4'd6, 4'd7, 2'b11, 4'd1, 1, 0, 0); step();
        drive(1, 4'd1, 4'd5, 2'b11, 4'd4, 1, 0, 0); step();
        nop(); eval_cycle();
        chk("young.fwd0", 32'(a_fwd[1:0]), 2);
        adv();

        // LDR r1,[r2] ; ADD r3,r1,r1 on the default depth
        do_reset();
        drive(1, 4'd2, 4'd0, 2'b01, 4'd1, 1, 1, 0); step();
        drive(1, 4'd1, 4'd1, 2'b11, 4'd3, 1, 0, 0); eval_cycle();
        chk("ldr.c1.stall_f", 32'(a_stall_f), 1);
        chk("ldr.c1.stall_d", 32'(a_stall_d), 1);
        chk("ldr.c1.flush_e", 32'(a_flush_e), 1);
        adv();
        eval_cycle();
        chk("ldr.c2.stall_d", 32'(a_stall_d), 0);
        chk("ldr.c2.bubble", 32'(a_fwd), 0);
        adv();
        nop(); eval_cycle();
        chk("ldr.c3.fwd0", 32'(a_fwd[1:0]), 3);
        chk("ldr.c3.fwd1", 32'(a_fwd[3:2]), 3);
        chk("ldr.count", 32'(a_cnt), 1);
        adv();

        // Same load-use on the 4/4 instance: two stall cycles, then forward from stage 4
        do_reset();
        drive(1, 4'd2, 4'd0, 2'b01, 4'd1, 1, 1, 0); step();
        drive(1, 4'd1, 4'd1, 2'b11, 4'd3, 1, 0, 0); eval_cycle();
        chk("deep.c1.stall", 32'(b_stall_d), 1);
        adv(); eval_cycle();
        chk("deep.c2.stall", 32'(b_stall_d), 1);
        adv(); eval_cycle();
        chk("deep.c3.stall", 32'(b_stall_d), 0);
        adv();
        nop(); eval_cycle();
        chk("deep.fwd0", 32'(b_fwd[2:0]), 4);
        chk("deep.fwd1", 32'(b_fwd[5:3]), 4);
        chk("deep.count", 32'(b_cnt), 2);
        adv();

        // Branch taken together with a load-use hazard
        do_reset();
        drive(1, 4'd2, 4'd0, 2'b01, 4'd1, 1, 1, 0); step();
        drive(1, 4'd1, 4'd1, 2'b11, 4'd3, 1, 0, 1); eval_cycle();
        chk("br.flush_d", 32'(a_flush_d), 1);
        chk("br.flush_e", 32'(a_flush_e), 1);
        chk("br.stall_d", 32'(a_stall_d), 0);
        adv();
        nop(); eval_cycle();
        chk("br.count", 32'(a_cnt), 0);
        adv();

        // PC destination never forwards or stalls; unused operands never stall
        drive(1, 4'd2, 4'd0, 2'b01, 4'd15, 1, 0, 0); step();
        drive(1, 4'd15, 4'd0, 2'b01, 4'd4, 1, 0, 0); step();
        nop(); eval_cycle();
        chk("pc.fwd0", 32'(a_fwd[1:0]), 0);
        adv();
        drive(1, 4'd2, 4'd0, 2'b01, 4'd15, 1, 1, 0); step();
        drive(1, 4'd15, 4'd0, 2'b01, 4'd4, 1, 0, 0); eval_cycle();
        chk("pc.stall", 32'(a_stall_d), 0);
        adv();
        drive(1, 4'd2, 4'd0, 2'b01, 4'd1, 1, 1, 0); step();
        drive(1, 4'd1, 4'd1, 2'b00, 4'd4, 1, 0, 0); eval_cycle();
        chk("unused.stall", 32'(a_stall_d), 0);
        adv();

        // Reset asserted in the middle of a stall
        drive(1, 4'd2, 4'd0, 2'b01, 4'd1, 1, 1, 0); step();
        drive(1, 4'd1, 4'd1, 2'b11, 4'd3, 1, 0, 0); eval_cycle();
        chk("midrst.pre", 32'(a_stall_d), 1);
        #1 reset = 1'b1;
        br_taken_e = 1'b1;
        #1 check_zero("midrst");
        br_taken_e = 1'b0;
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        drive(1, 4'd2, 4'd3, 2'b11, 4'd1, 1, 0, 0); step();
        drive(1, 4'd1, 4'd5, 2'b11, 4'd4, 1, 0, 0); step();
        nop(); step();

        // Random traffic over a small register set so hazards are frequent
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 3) != 0), pick_reg(), pick_reg(), 2'($urandom_range(0, 3)),
                  pick_reg(), ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 7) == 0));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
